fadd_wb_queue: RTL
==================

FADD_WB_QUEUE -- requirements
Module: fadd_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 Parameter LAT, default 2, fadd clock latency (operands applied in cycle T, y valid in cycle T+LAT).
REQ-003 Parameter TAG_W, default 5, destination-register tag width.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock, shared with fadd.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  issue request.
REQ-008 in_ready  out  1  issue accepted when in_valid && in_ready.
REQ-009 in_x1, in_x2  in  32  IEEE-754 single operands.
REQ-010 in_tag  in  TAG_W  destination tag.
REQ-011 fadd_x1, fadd_x2  out  32  operands to fadd, driven combinationally equal to in_x1/in_x2.
REQ-012 fadd_y  in  32  fadd result.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-015 out_y  out  32; out_tag  out  TAG_W  result and its tag.
REQ-016 busy  out  1  high when any op is in flight or the FIFO is non-empty.

Function
REQ-017 The block SHALL track each accepted issue through a LAT-stage valid/tag shift register; stage LAT-1 valid means fadd_y in the current cycle belongs to that tag.
REQ-018 When stage LAT-1 is valid, {fadd_y, tag} SHALL be written to the FIFO at that clock edge; results are never dropped.
REQ-019 Credit rule: in_ready SHALL equal (fifo_count + inflight_count) < DEPTH, computed from registers only; a same-cycle pop does not raise in_ready.
REQ-020 fadd has no stall; the credit rule is the only overflow protection, and a FIFO write when full SHALL be impossible by construction.
REQ-021 out_valid SHALL equal FIFO non-empty; out_y/out_tag SHALL be the FIFO head; pop occurs on out_valid && out_ready.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged; pop-then-push at the same head index SHALL return the older entry first.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits.
REQ-024 Results SHALL exit in issue order; latency issue->out_valid is LAT+1 cycles when the FIFO is empty.
REQ-025 Issue with in_valid && !in_ready SHALL not enter the shift register; fadd_x1/x2 still follow the inputs, and the result is ignored.

Reset
REQ-026 While rst is high: all shift-register valid bits, FIFO pointers and counts SHALL be 0; in_ready=1 (with DEPTH>=1), out_valid=0, busy=0, out_y=0, out_tag=0.
REQ-027 Reset mid-operation SHALL discard in-flight and buffered results; fadd outputs in the following LAT cycles SHALL be ignored.

Configuration
REQ-028 Macro FADD_WB_BYPASS_EN: when defined, if the FIFO is empty and stage LAT-1 is valid, out_valid SHALL assert in that same cycle with out_y=fadd_y; if out_ready is also high there, no FIFO write occurs (latency LAT); otherwise the entry is written as usual.
REQ-029 Without FADD_WB_BYPASS_EN, all results SHALL pass through the FIFO (latency LAT+1); out_* are purely register-driven.

Structure
REQ-030 Package fpu_pkg SHALL hold FADD_LAT=2, TAG_W default, and typedef fadd_res_t {logic [31:0] y; logic [TAG_W-1:0] tag;}.
REQ-031 The FIFO SHALL be a sub-module fpu_result_fifo (DEPTH, fadd_res_t, push/pop/full/empty/count); the shift register and credit logic stay in fadd_wb_queue.

Verification
REQ-032 Issue 0x3F800000 + 0x40000000, tag 3, in cycle T, out_ready=1 -> out_valid in T+3 (T+2 with bypass), out_y=0x40400000, out_tag=3.
REQ-033 out_ready=0, in_valid=1 for 8 cycles with tags 0..7 -> exactly 4 accepted (in_ready low from cycle 4), FIFO full; then out_ready=1 -> tags 0,1,2,3 in order, in_ready rises the cycle after the first pop.
REQ-034 Back-to-back issue every cycle, out_ready=1 -> one result per cycle in order, in_ready never drops, no FIFO overflow.
REQ-035 Issue 1.0 + (-1.0), tag 9 -> out_y=0x00000000, out_tag=9.
REQ-036 Assert rst one cycle after two issues -> out_valid stays 0, busy=0, in_ready=1 next cycle; no stale result emerges in later cycles.
REQ-037 Simultaneous push/pop with FIFO at count 2, including pointer wrap at index DEPTH-1 -> count stays 2, order preserved.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU writeback types: fadd pipeline latency, default tag width and the
// result record carried through the writeback queue.
package fpu_pkg;

    localparam int FADD_LAT   = 2;
    localparam int FADD_TAG_W = 5;

    typedef struct packed {
        logic [31:0]           y;
        logic [FADD_TAG_W-1:0] tag;
    } fadd_res_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO for the fadd writeback queue. The head is combinational from the
// storage array and reads as zero while empty.
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fadd_res_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output T                       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        head_o = '0;
        if (!empty_o) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fadd_wb_queue.sv
// Writeback queue for a fixed-latency, non-stalling fadd: tags issues through a
// LAT-deep shift register and buffers results under a credit rule. Option: FADD_WB_BYPASS_EN.
module fadd_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = FADD_LAT,
    parameter int TAG_W = FADD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fadd_x1,
    output logic [31:0]      fadd_x2,
    input  logic [31:0]      fadd_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LAT-1:0]   vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic             issue;
    logic             wb_valid;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    res_t             wb_res, fifo_head;
    int               inflight;

    assign fadd_x1  = in_x1;
    assign fadd_x2  = in_x2;
    assign wb_valid = vld_q[LAT-1];
    assign wb_res   = {fadd_y, tag_q[LAT-1]};

    // Every in-flight op already owns a FIFO slot, so fadd never needs to stall.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) begin
            if (vld_q[i]) begin
                inflight++;
            end
        end
    end

    assign in_ready = (int'(fifo_count) + inflight) < DEPTH;
    assign issue    = in_valid && in_ready;

    always_comb begin
        vld_d[0] = issue;
        tag_d[0] = in_tag;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

`ifdef FADD_WB_BYPASS_EN
    logic bypass;

    assign bypass    = fifo_empty && wb_valid;
    assign fifo_push = wb_valid && !(bypass && out_ready);
    assign out_valid = !fifo_empty || bypass;
    assign out_y     = bypass ? fadd_y : fifo_head.y;
    assign out_tag   = bypass ? tag_q[LAT-1] : fifo_head.tag;
`else
    assign fifo_push = wb_valid;
    assign out_valid = !fifo_empty;
    assign out_y     = fifo_head.y;
    assign out_tag   = fifo_head.tag;
`endif

    assign fifo_pop = out_ready && !fifo_empty;
    assign busy     = (|vld_q) || !fifo_empty;

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (wb_res),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    wb_no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule
